zion_clr_skid_buf: RTL and testbench
====================================

Name: zion_clr_skid_buf

Overview:
- Two-entry valid/ready register slice (skid buffer) with synchronous flush; it sits between a producer and a consumer that may stall.
- It is the read/backpressure-side counterpart to the library's clear/enable DFF: the producer pushes, the consumer pops, and iClr flushes both entries back to INI_DATA.
- All outputs are registered, so there is no combinational path from iRdy to oRdy. It is used to break timing on handshake pipelines.

Parameters:
- WIDTH, 32, payload width in bits.
- INI_DATA, 32'h1, value of oDat and of both entry registers after reset/clear and when empty (width WIDTH).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- iClr  in  1  synchronous flush; drops all held data.
- iVld  in  1  producer data valid.
- oRdy  out  1  slice can accept (registered).
- iDat  in  WIDTH  producer payload.
- oVld  out  1  output data valid (registered).
- iRdy  in  1  consumer ready.
- oDat  out  WIDTH  output payload (registered).
- oCnt  out  2  occupancy, 0..2.

Behaviour:
- Definitions: push = iVld & oRdy; pop = oVld & iRdy. Both are sampled on posedge clk.
- Storage: a main register drives oDat; a skid register holds a second word.
- States: EMPTY (oCnt=0, oVld=0, oRdy=1), ONE (oCnt=1, oVld=1, oRdy=1), FULL (oCnt=2, oVld=1, oRdy=0). oVld, oRdy and oCnt are decoded from the state register only.
- Reset (rst=1 at posedge): state becomes EMPTY, main=skid=INI_DATA. Outputs after reset: oVld=0, oRdy=1, oCnt=0, oDat=INI_DATA.
- Priority: rst > iClr > push/pop.
- Clear (iClr=1, rst=0): same result as reset, in one cycle. A push or pop presented in the same cycle is discarded; the consumer must not count a pop in that cycle.
- Transitions from EMPTY:
  - push -> ONE, main<=iDat.
  - no push -> stay EMPTY.
- Transitions from ONE:
  - push & pop -> ONE, main<=iDat.
  - push & !pop -> FULL, skid<=iDat, main held.
  - pop & !push -> EMPTY, main<=INI_DATA.
  - neither -> hold.
- Transitions from FULL (push is impossible since oRdy=0):
  - pop -> ONE, main<=skid, skid<=INI_DATA.
  - no pop -> hold.
- Latency: 1 cycle from push to oVld/oDat.
- Throughput: 1 word/cycle sustained when iRdy stays high.
- Ordering: strict FIFO, with no loss or duplication.
- Stability: while oVld=1 and iRdy=0, oDat and oVld hold constant.
- iDat/iVld are ignored when oRdy=0. iVld is not required to be held by this block.
- Reset or clear mid-transfer drops everything and causes no X propagation. With rst held high, outputs stay at reset values every cycle.

Decomposition:
- Shared package zion_skid_pkg:
  - typedef enum logic[1:0] {EMPTY=0, ONE=1, FULL=2} skid_state_e;
  - the oCnt width constant (2).
- Sub-module: main and skid data registers are instances of ZionBasicCircuitLib_ClrEnRcDff, configured as follows:
  - RST_CFG=3 (synchronous, active-high), INI_DATA passed through.
  - iClr driven by iClr or a pop-to-empty condition.
  - iEn driven by the load conditions above.
- The state register and next-state/enable logic live in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> oVld=0, oRdy=1, oCnt=0, oDat=32'h1 during reset and the first cycle after.
- Streaming: iRdy=1, iVld=1, iDat=0xA0,0xA1,0xA2,0xA3 on consecutive cycles -> oDat=0xA0..0xA3 one cycle later each, oVld continuous, oRdy stays 1, oCnt=1.
- Backpressure: iRdy=0, push 0x10 then 0x20 -> oCnt=2, oRdy=0, oDat=0x10. The following push of 0x30 while oRdy=0 is ignored. Then iRdy=1 -> pops 0x10, 0x20, oCnt 2→1→0, oDat returns to 0x1.
- Simultaneous push/pop in ONE: holding 0x55, iVld=1 with iDat=0x66 and iRdy=1 -> next cycle oDat=0x66, oCnt=1.
- Clear priority: FULL with 0x10/0x20, assert iClr with iVld=1, iRdy=1 -> next cycle oCnt=0, oVld=0, oDat=0x1; 0x10/0x20 are never seen again. Then rst=1 together with iClr=0 and a push -> still EMPTY.
- Random: 2000 cycles of random iVld/iRdy/iClr (iClr about 2%), checked against a scoreboard queue model -> order preserved, no loss, oDat stable under stall, oCnt matches the model.

Source files
------------

// File: rtl/zion_skid_pkg.sv
// Shared types and constants for the two-entry clearable skid buffer.
package zion_skid_pkg;

  // Occupancy state of the slice; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Width of the occupancy output (counts 0..2).
  localparam int CNT_W = 2;

endpackage : zion_skid_pkg

// File: rtl/ZionBasicCircuitLib_ClrEnRcDff.sv
// Library D flip-flop with clear and enable and a selectable reset style.
// RST_CFG: 0 async active-low, 1 async active-high,
//          2 sync active-low, 3 sync active-high.
// Clear takes priority over enable; both load INI_DATA / iDat on the clock edge.
module ZionBasicCircuitLib_ClrEnRcDff #(
  parameter int               WIDTH    = 32,
  parameter int               RST_CFG  = 3,
  parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iDat,
  output logic [WIDTH-1:0] oDat
);

  generate
    if (RST_CFG == 0) begin : g_async_low
      // Register with asynchronous active-low reset.
      always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst)      oDat <= INI_DATA;
        else if (iClr) oDat <= INI_DATA;
        else if (iEn)  oDat <= iDat;
      end
    end else if (RST_CFG == 1) begin : g_async_high
      // Register with asynchronous active-high reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       oDat <= INI_DATA;
        else if (iClr) oDat <= INI_DATA;
        else if (iEn)  oDat <= iDat;
      end
    end else begin : g_sync
      // Reset is just another synchronous clear; only its polarity differs.
      logic rst_act;
      assign rst_act = (RST_CFG == 2) ? !rst : rst;

      // Register with synchronous reset.
      always_ff @(posedge clk) begin
        if (rst_act)   oDat <= INI_DATA;
        else if (iClr) oDat <= INI_DATA;
        else if (iEn)  oDat <= iDat;
      end
    end
  endgenerate

endmodule : ZionBasicCircuitLib_ClrEnRcDff

// File: rtl/zion_clr_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush.
// All handshake outputs decode from the state register, so oRdy never
// depends combinationally on iRdy. The main register drives oDat; the skid
// register catches the word that arrives while the consumer stalls.
module zion_clr_skid_buf
  import zion_skid_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat,
  output logic [CNT_W-1:0] oCnt
);

  skid_state_e      state, state_nxt;
  logic             push, pop;
  logic             main_en, main_clr, skid_en, skid_clr;
  logic [WIDTH-1:0] main_din, skid_q;

  assign oVld = (state != EMPTY);
  assign oRdy = (state != FULL);
  assign oCnt = CNT_W'(state);
  assign push = iVld & oRdy;
  assign pop  = oVld & iRdy;

  // State register; reset and flush both return to EMPTY.
  always_ff @(posedge clk) begin
    if (rst)       state <= EMPTY;
    else if (iClr) state <= EMPTY;
    else           state <= state_nxt;
  end

  // Next state plus load/clear strobes for the two data registers.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    main_en   = 1'b0;
    main_clr  = iClr;
    main_din  = iDat;
    skid_en   = 1'b0;
    skid_clr  = iClr;
    if (!iClr) begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            main_en   = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_en = 1'b1;
          end else if (push) begin
            state_nxt = FULL;
            skid_en   = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
            main_clr  = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt = ONE;
            main_en   = 1'b1;
            main_din  = skid_q;
            skid_clr  = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  ZionBasicCircuitLib_ClrEnRcDff #(
    .WIDTH    (WIDTH),
    .RST_CFG  (3),
    .INI_DATA (INI_DATA)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .iClr (main_clr),
    .iEn  (main_en),
    .iDat (main_din),
    .oDat (oDat)
  );

  ZionBasicCircuitLib_ClrEnRcDff #(
    .WIDTH    (WIDTH),
    .RST_CFG  (3),
    .INI_DATA (INI_DATA)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .iClr (skid_clr),
    .iEn  (skid_en),
    .iDat (iDat),
    .oDat (skid_q)
  );

endmodule : zion_clr_skid_buf

// File: tb/tb_zion_clr_skid_buf.sv
// Self-checking bench for zion_clr_skid_buf: directed scenarios with fixed
// expectations, then random traffic against a queue-based reference model.
module tb_zion_clr_skid_buf;

  localparam int          WIDTH = 32;
  localparam logic [31:0] INI   = 32'h1;

  logic             clk = 1'b0;
  logic             rst, iClr, iVld, iRdy;
  logic [WIDTH-1:0] iDat;
  logic             oRdy, oVld;
  logic [WIDTH-1:0] oDat;
  logic [1:0]       oCnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the words held by the slice, oldest first.
  logic [WIDTH-1:0] q[$];

  always #5 clk = ~clk;

  zion_clr_skid_buf #(.WIDTH(WIDTH), .INI_DATA(INI)) dut (
    .clk  (clk),
    .rst  (rst),
    .iClr (iClr),
    .iVld (iVld),
    .oRdy (oRdy),
    .iDat (iDat),
    .oVld (oVld),
    .iRdy (iRdy),
    .oDat (oDat),
    .oCnt (oCnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all outputs with the reference model.
  task automatic check_model(input string tag);
    int unsigned n;
    n = q.size();
    check({tag, ".vld"}, 32'(oVld), 32'(n > 0));
    check({tag, ".rdy"}, 32'(oRdy), 32'(n < 2));
    check({tag, ".cnt"}, 32'(oCnt), 32'(n));
    check({tag, ".dat"}, oDat, (n > 0) ? q[0] : INI);
  endtask

  // Compare all outputs with fixed expected values.
  task automatic expect_out(input string tag, input logic v, input logic r,
                            input logic [1:0] c, input logic [31:0] d);
    check({tag, ".vld"}, 32'(oVld), 32'(v));
    check({tag, ".rdy"}, 32'(oRdy), 32'(r));
    check({tag, ".cnt"}, 32'(oCnt), 32'(c));
    check({tag, ".dat"}, oDat, d);
  endtask

  // One clock: drive inputs (at a negedge), advance the model at the posedge,
  // then sample and compare at the following negedge.
  task automatic cycle(input string tag, input logic v, input logic [31:0] d,
                       input logic r, input logic c, input logic rs);
    logic do_push, do_pop;
    iVld = v; iDat = d; iRdy = r; iClr = c; rst = rs;
    @(posedge clk);
    if (rs || c) begin
      q.delete();
    end else begin
      do_push = v && (q.size() < 2);
      do_pop  = r && (q.size() > 0);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; iClr = 1'b0; iVld = 1'b0; iRdy = 1'b0; iDat = '0;

    // Reset held for two cycles, then released.
    @(negedge clk);
    expect_out("rst0", 1'b0, 1'b1, 2'd0, INI);
    cycle("rst1", 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b1);
    expect_out("rst1c", 1'b0, 1'b1, 2'd0, INI);
    cycle("rst_rel", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("rst_relc", 1'b0, 1'b1, 2'd0, INI);

    // Streaming at full rate.
    for (int i = 0; i < 4; i++) begin
      cycle("stream", 1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0, 1'b0);
      expect_out("streamc", 1'b1, 1'b1, 2'd1, 32'hA0 + 32'(i));
    end
    cycle("drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_out("drainc", 1'b0, 1'b1, 2'd0, INI);

    // Backpressure fills both entries; push while full is ignored.
    cycle("bp10", 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    expect_out("bp10c", 1'b1, 1'b1, 2'd1, 32'h10);
    cycle("bp20", 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    expect_out("bp20c", 1'b1, 1'b0, 2'd2, 32'h10);
    cycle("bp30", 1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
    expect_out("bp30c", 1'b1, 1'b0, 2'd2, 32'h10);
    cycle("pop10", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_out("pop10c", 1'b1, 1'b1, 2'd1, 32'h20);
    cycle("pop20", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_out("pop20c", 1'b0, 1'b1, 2'd0, INI);

    // Simultaneous push and pop while holding one word.
    cycle("hold55", 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    expect_out("hold55c", 1'b1, 1'b1, 2'd1, 32'h55);
    cycle("pp66", 1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
    expect_out("pp66c", 1'b1, 1'b1, 2'd1, 32'h66);
    cycle("pp_drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Clear beats push/pop; reset beats push.
    cycle("fill10", 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    cycle("fill20", 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    expect_out("fullc", 1'b1, 1'b0, 2'd2, 32'h10);
    cycle("clr", 1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
    expect_out("clrc", 1'b0, 1'b1, 2'd0, INI);
    cycle("post_clr", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_out("post_clrc", 1'b0, 1'b1, 2'd0, INI);
    cycle("rst_push", 1'b1, 32'h88, 1'b1, 1'b0, 1'b1);
    expect_out("rst_pushc", 1'b0, 1'b1, 2'd0, INI);

    // Random traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_zion_clr_skid_buf
